alu_issue: RTL and testbench

- Initiator side of the ALU execution-unit handshake (dowork/done).
- Buffers decoded ALU requests in a small in-order queue and drives each one into the execution unit.
- Holds operands stable until done, captures result, and returns it with its tag on a valid/ready response channel.
- Sits between decode and the ALU execution unit in the core.

---
 rtl/alu_pkg.sv | 15 +
 rtl/alu_req_fifo.sv | 57 +++++
 rtl/alu_issue.sv | 154 +++++++++++++++
 tb/tb_alu_issue.sv | 260 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/alu_pkg.sv
// Shared types for the ALU issue slice: request payload and issue FSM states.
package alu_pkg;

    localparam logic [5:0] ALU_FN_ADD = 6'd0;

    typedef struct packed {
        logic [31:0] op_1;
        logic [31:0] op_2;
        logic [5:0]  fn;
        logic [15:0] imm;
    } alu_req_t;

    typedef enum logic [1:0] {IDLE, ISSUE, RESP} alu_issue_state_t;

endpackage

// File: rtl/alu_req_fifo.sv
// In-order request queue of {alu_req_t, tag}; DEPTH must be a power of two so pointers wrap naturally.
module alu_req_fifo
    import alu_pkg::*;
#(
    parameter int DEPTH = 4,
    parameter int TAG_W = 5
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     push,
    input  alu_req_t                 push_req,
    input  logic [TAG_W-1:0]         push_tag,
    input  logic                     pop,
    output alu_req_t                 pop_req,
    output logic [TAG_W-1:0]         pop_tag,
    output logic                     full,
    output logic                     empty,
    output logic [$clog2(DEPTH):0]   count
);
    localparam int AW = $clog2(DEPTH);

    alu_req_t         mem_req [DEPTH];
    logic [TAG_W-1:0] mem_tag [DEPTH];
    logic [AW-1:0]    wr_ptr, rd_ptr;
    logic             do_push, do_pop;

    assign full    = (count == (AW+1)'(DEPTH));
    assign empty   = (count == '0);
    assign do_push = push && !full;
    assign do_pop  = pop && !empty;
    assign pop_req = mem_req[rd_ptr];
    assign pop_tag = mem_tag[rd_ptr];

    always_ff @(posedge clk) begin
        if (do_push) begin
            mem_req[wr_ptr] <= push_req;
            mem_tag[wr_ptr] <= push_tag;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + 1'b1;
            if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
            case ({do_push, do_pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

endmodule

// File: rtl/alu_issue.sv
// Queues decoded ALU requests and runs them one at a time through the dowork/done exec handshake.
// Optional ALU_ISSUE_TIMEOUT_EN adds rsp_err and aborts an ISSUE that waits TIMEOUT+1 cycles.
module alu_issue
    import alu_pkg::*;
#(
    parameter int DEPTH   = 4,
    parameter int TAG_W   = 5,
    parameter int TIMEOUT = 15
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             req_valid,
    output logic             req_ready,
    input  logic [31:0]      req_op_1,
    input  logic [31:0]      req_op_2,
    input  logic [5:0]       req_fn,
    input  logic [15:0]      req_imm,
    input  logic [TAG_W-1:0] req_tag,
    output logic             dowork,
    input  logic             done,
    output logic [31:0]      op_1,
    output logic [31:0]      op_2,
    output logic [5:0]       fn,
    output logic [15:0]      immediate,
    input  logic [31:0]      result,
    output logic             rsp_valid,
    input  logic             rsp_ready,
    output logic [31:0]      rsp_result,
    output logic [TAG_W-1:0] rsp_tag,
`ifdef ALU_ISSUE_TIMEOUT_EN
    output logic             rsp_err,
`endif
    output logic             busy
);
    alu_issue_state_t       state, state_d;
    alu_req_t               head_req;
    logic [TAG_W-1:0]       head_tag, cur_tag;
    logic                   fifo_full, fifo_empty;
    logic [$clog2(DEPTH):0] fifo_count;
    logic                   pop, load, capture, abort, rsp_clr;

    alu_req_fifo #(.DEPTH(DEPTH), .TAG_W(TAG_W)) u_fifo (
        .clk      (clk),
        .reset    (reset),
        .push     (req_valid && req_ready),
        .push_req ('{op_1: req_op_1, op_2: req_op_2, fn: req_fn, imm: req_imm}),
        .push_tag (req_tag),
        .pop      (pop),
        .pop_req  (head_req),
        .pop_tag  (head_tag),
        .full     (fifo_full),
        .empty    (fifo_empty),
        .count    (fifo_count)
    );

    // Registered count only: a pop this cycle never opens a slot for a push this cycle.
    assign req_ready = !fifo_full;
    assign busy      = (state != IDLE) || (fifo_count != '0);

`ifdef ALU_ISSUE_TIMEOUT_EN
    localparam int TW = $clog2(TIMEOUT + 1);
    logic [TW-1:0] tmo_cnt;
    logic          tmo_hit;
    assign tmo_hit = (tmo_cnt == TW'(TIMEOUT));
`else
    logic          tmo_hit;
    assign tmo_hit = 1'b0;
`endif

    always_ff @(posedge clk) begin
        if (reset) state <= IDLE;
        else       state <= state_d;
    end

    always_comb begin
        state_d = state;
        pop     = 1'b0;
        load    = 1'b0;
        capture = 1'b0;
        abort   = 1'b0;
        rsp_clr = 1'b0;
        case (state)
            IDLE: if (!fifo_empty) begin
                pop     = 1'b1;
                load    = 1'b1;
                state_d = ISSUE;
            end
            ISSUE: if (done) begin
                capture = 1'b1;
                state_d = RESP;
            end else if (tmo_hit) begin
                abort   = 1'b1;
                state_d = RESP;
            end
            RESP: if (rsp_ready) begin
                rsp_clr = 1'b1;
                if (!fifo_empty) begin
                    pop     = 1'b1;
                    load    = 1'b1;
                    state_d = ISSUE;
                end else begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            dowork     <= 1'b0;
            op_1       <= '0;
            op_2       <= '0;
            fn         <= '0;
            immediate  <= '0;
            cur_tag    <= '0;
            rsp_valid  <= 1'b0;
            rsp_result <= '0;
            rsp_tag    <= '0;
        end else begin
            if (rsp_clr) rsp_valid <= 1'b0;
            if (load) begin
                op_1      <= head_req.op_1;
                op_2      <= head_req.op_2;
                fn        <= head_req.fn;
                immediate <= head_req.imm;
                cur_tag   <= head_tag;
                dowork    <= 1'b1;
            end
            // dowork drops on the done edge so the exec unit never reruns this request
            if (capture || abort) begin
                dowork     <= 1'b0;
                rsp_valid  <= 1'b1;
                rsp_result <= capture ? result : 32'h0;
                rsp_tag    <= cur_tag;
            end
        end
    end

`ifdef ALU_ISSUE_TIMEOUT_EN
    always_ff @(posedge clk) begin
        if (reset) begin
            tmo_cnt <= '0;
            rsp_err <= 1'b0;
        end else begin
            if (load)                tmo_cnt <= '0;
            else if (state == ISSUE) tmo_cnt <= tmo_cnt + 1'b1;
            if (rsp_clr || capture)  rsp_err <= 1'b0;
            if (abort)               rsp_err <= 1'b1;
        end
    end
`endif

endmodule

// File: tb/tb_alu_issue.sv
// Directed bench for alu_issue with a one-cycle-latency adder acting as the exec unit.
module tb_alu_issue;
    import alu_pkg::*;

    logic        clk = 0, reset = 1;
    logic        req_valid = 0, rsp_ready = 0;
    logic [31:0] req_op_1 = 0, req_op_2 = 0;
    logic [5:0]  req_fn = 0;
    logic [15:0] req_imm = 0;
    logic [4:0]  req_tag = 0;
    logic        req_ready, dowork, rsp_valid, busy, done;
    logic [31:0] op_1, op_2, rsp_result, result;
    logic [5:0]  fn;
    logic [15:0] immediate;
    logic [4:0]  rsp_tag;
`ifdef ALU_ISSUE_TIMEOUT_EN
    logic        rsp_err;
`endif

    // exec unit model: pulses done one cycle after seeing dowork, result = op_1+op_2+zext(imm)
    logic        rdone = 0, mute = 0, force_done = 0;
    logic [31:0] rres = 0;
    int          ndone = 0;
    assign done   = (rdone & ~mute) | force_done;
    assign result = rres;

    always #5 clk = ~clk;

    always @(posedge clk) begin
        if (reset) rdone <= 1'b0;
        else       rdone <= dowork && !rdone;
        rres <= op_1 + op_2 + {16'h0, immediate};
        if (done) ndone <= ndone + 1;
    end

    alu_issue #(.DEPTH(4), .TAG_W(5), .TIMEOUT(15)) dut (
        .clk(clk), .reset(reset), .req_valid(req_valid), .req_ready(req_ready),
        .req_op_1(req_op_1), .req_op_2(req_op_2), .req_fn(req_fn), .req_imm(req_imm),
        .req_tag(req_tag), .dowork(dowork), .done(done), .op_1(op_1), .op_2(op_2),
        .fn(fn), .immediate(immediate), .result(result), .rsp_valid(rsp_valid),
        .rsp_ready(rsp_ready), .rsp_result(rsp_result), .rsp_tag(rsp_tag),
`ifdef ALU_ISSUE_TIMEOUT_EN
        .rsp_err(rsp_err),
`endif
        .busy(busy)
    );

    typedef struct {
        logic [31:0] op1;
        logic [31:0] op2;
        logic [15:0] imm;
        logic [5:0]  fn;
        logic [4:0]  tag;
        logic [31:0] exp;
    } vec_t;

    int tests = 0, fails = 0;

    task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %h, expected %h", nm, act, exp);
        end
    endtask

    task automatic drive(input vec_t v);
        req_valid = 1; req_op_1 = v.op1; req_op_2 = v.op2;
        req_imm = v.imm; req_fn = v.fn; req_tag = v.tag;
    endtask

    // One request from IDLE with empty queue; checks the cycle-exact latency.
    task automatic run_one(input vec_t v);
        int d0;
        d0 = ndone;
        @(negedge clk);
        check("ready_before", req_ready, 1);
        drive(v);
        @(negedge clk);                      // after accept edge N
        req_valid = 0;
        check("dowork_N", dowork, 0);
        check("busy_N", busy, 1);
        @(negedge clk);                      // after N+1
        check("dowork_N1", dowork, 1);
        check("op_1", op_1, v.op1);
        check("op_2", op_2, v.op2);
        check("fn", fn, v.fn);
        check("immediate", immediate, v.imm);
        @(negedge clk);                      // after N+2
        check("dowork_N2", dowork, 1);
        check("done_N2", done, 1);
        check("rsp_valid_N2", rsp_valid, 0);
        @(negedge clk);                      // after N+3
        check("rsp_valid_N3", rsp_valid, 1);
        check("dowork_N3", dowork, 0);
        check("rsp_result", rsp_result, v.exp);
        check("rsp_tag", rsp_tag, v.tag);
        rsp_ready = 1;
        @(negedge clk);
        rsp_ready = 0;
        check("rsp_valid_clr", rsp_valid, 0);
        check("busy_idle", busy, 0);
        check("done_pulses", ndone - d0, 1);
    endtask

    vec_t tab [5];
    vec_t b2b [3];

    initial begin
        tab[0] = '{32'd5,         32'd7,         16'd3,      ALU_FN_ADD, 5'd2,  32'd15};
        tab[1] = '{32'hFFFFFFFF,  32'd1,         16'd0,      ALU_FN_ADD, 5'd3,  32'd0};
        tab[2] = '{32'd0,         32'd0,         16'hFFFF,   ALU_FN_ADD, 5'd4,  32'h0000FFFF};
        tab[3] = '{32'd100,       32'd200,       16'd0,      6'h2A,      5'd7,  32'd300};
        tab[4] = '{32'h80000000,  32'h80000000,  16'h1234,   6'h3F,      5'd31, 32'h00001234};
        b2b[0] = '{32'd1,    32'd2,  16'd0, ALU_FN_ADD, 5'd0, 32'd3};
        b2b[1] = '{32'd10,   32'd20, 16'd5, ALU_FN_ADD, 5'd1, 32'd35};
        b2b[2] = '{32'd1000, 32'd1,  16'd1, ALU_FN_ADD, 5'd2, 32'd1002};

        // reset with a request presented: it must be ignored
        req_valid = 1; req_op_1 = 32'hDEAD;
        repeat (2) @(negedge clk);
        req_valid = 0;
        reset = 0;
        @(negedge clk);
        check("rst_req_ready", req_ready, 1);
        check("rst_dowork", dowork, 0);
        check("rst_rsp_valid", rsp_valid, 0);
        check("rst_busy", busy, 0);
        check("rst_op_1", op_1, 0);
        check("rst_rsp_result", rsp_result, 0);
        check("rst_rsp_tag", rsp_tag, 0);

        for (int i = 0; i < 5; i++) run_one(tab[i]);

        // done outside ISSUE is ignored
        @(negedge clk); force_done = 1;
        @(negedge clk); force_done = 0;
        check("stray_done_rsp", rsp_valid, 0);
        check("stray_done_busy", busy, 0);

        // three back-to-back requests, rsp_ready held high
        begin
            int d0, nr;
            logic prev_done;
            d0 = ndone; nr = 0; prev_done = 0;
            rsp_ready = 1;
            for (int c = 0; c < 40; c++) begin
                @(negedge clk);
                if (prev_done) check("b2b_dowork_fall", dowork, 0);
                prev_done = done;
                if (rsp_valid) begin
                    if (nr < 3) begin
                        check("b2b_tag", rsp_tag, b2b[nr].tag);
                        check("b2b_result", rsp_result, b2b[nr].exp);
                    end
                    nr++;
                end
                if (c < 3) drive(b2b[c]);
                else       req_valid = 0;
            end
            rsp_ready = 0;
            check("b2b_count", nr, 3);
            check("b2b_done_pulses", ndone - d0, 3);
        end

        // capacity with rsp_ready low: DEPTH+1 accepted, then backpressure
        begin
            int acc, nr;
            vec_t v;
            acc = 0;
            @(negedge clk);
            for (int c = 0; c < 10; c++) begin
                if (req_ready) begin
                    v = '{acc, 32'd100, 16'd0, ALU_FN_ADD, 5'(10 + acc), 32'd0};
                    drive(v);
                    acc++;
                end else req_valid = 0;
                @(negedge clk);
            end
            req_valid = 0;
            check("cap_accepted", acc, 5);
            check("cap_ready_low", req_ready, 0);
            check("cap_head_tag", rsp_tag, 10);
            check("cap_head_result", rsp_result, 100);
            rsp_ready = 1;
            @(negedge clk);
            rsp_ready = 0;
            check("cap_ready_back", req_ready, 1);
            nr = 0;
            rsp_ready = 1;
            for (int c = 0; c < 30; c++) begin
                @(negedge clk);
                if (rsp_valid) begin
                    check("cap_tag", rsp_tag, 11 + nr);
                    check("cap_result", rsp_result, 101 + nr);
                    nr++;
                end
            end
            rsp_ready = 0;
            check("cap_drained", nr, 4);
            check("cap_busy", busy, 0);
        end

        // reset while in ISSUE
        @(negedge clk);
        drive(tab[0]);
        @(negedge clk); req_valid = 0;
        @(negedge clk);
        check("mid_in_issue", dowork, 1);
        reset = 1;
        @(negedge clk);
        reset = 0;
        check("mid_dowork", dowork, 0);
        check("mid_rsp_valid", rsp_valid, 0);
        check("mid_req_ready", req_ready, 1);
        check("mid_busy", busy, 0);
        repeat (3) @(negedge clk);
        check("mid_no_rsp", rsp_valid, 0);
        run_one(tab[2]);

`ifdef ALU_ISSUE_TIMEOUT_EN
        begin
            int k;
            mute = 1;
            @(negedge clk);
            drive(tab[0]);
            @(negedge clk); req_valid = 0;
            @(negedge clk);
            check("tmo_dowork", dowork, 1);
            k = 0;
            for (int c = 0; c < 40; c++) begin
                @(negedge clk);
                k++;
                if (rsp_valid) break;
            end
            check("tmo_latency", k, 16);
            check("tmo_err", rsp_err, 1);
            check("tmo_result", rsp_result, 0);
            check("tmo_dowork_low", dowork, 0);
            rsp_ready = 1;
            @(negedge clk);
            rsp_ready = 0;
            check("tmo_err_clr", rsp_err, 0);
            mute = 0;
            run_one(tab[0]);
            check("tmo_norm_err", rsp_err, 0);
        end
`endif

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, expected completion");
        $fatal(1);
    end

endmodule
